kernel_a_vout_packer: RTL and testbench

KERNEL_A_VOUT_PACKER -- requirements
Module: kernel_A_vout_packer

---
 rtl/kernel_a_vout_packer.sv | 117 +++++++++++
 tb/tb_kernel_a_vout_packer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kernel_a_vout_packer.sv
// Packs PACK consecutive STREAMW-bit stream elements into one wide word,
// buffers finished words in a 2-entry FIFO and flags completion of an NELEMS run.
module kernel_a_vout_packer #(
   parameter int STREAMW = 32,
   parameter int PACK    = 4,
   parameter int NELEMS  = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ivalid,
   output logic                      iready,
   input  logic [STREAMW-1:0]        in_s0,
   output logic                      ovalid,
   input  logic                      oready,
   output logic [PACK*STREAMW-1:0]   out_s0,
   output logic                      done
);

   localparam int LW = $clog2(PACK);
   localparam int EW = $clog2(NELEMS + 1);
   localparam int WW = PACK * STREAMW;
   localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);
   localparam logic [EW-1:0] LAST_ECNT = EW'(NELEMS - 1);

   generate
      if (PACK < 2 || PACK > 16) begin : g_bad_pack
         $error("kernel_a_vout_packer: PACK must be in 2..16");
      end
      if (NELEMS % PACK != 0) begin : g_bad_nelems
         $error("kernel_a_vout_packer: NELEMS must be a multiple of PACK");
      end
   endgenerate

   typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} state_t;

   state_t          state_reg;
   logic [LW-1:0]   lane_reg;
   logic [EW-1:0]   ecnt_reg;
   logic [WW-1:0]   asm_reg;
   logic [WW-1:0]   fifo_mem [2];
   logic            wr_ptr_reg;
   logic            rd_ptr_reg;
   logic [1:0]      count_reg;

   logic            last_lane;
   logic            accept;
   logic            push;
   logic            pop;
   logic [WW-1:0]   word_next;

   assign last_lane = (lane_reg == LAST_LANE);
   // rst gates iready so the upstream sees "not ready" for the whole reset pulse.
   assign iready    = !rst && (state_reg == S_FILL) && (!last_lane || (count_reg < 2'd2));
   assign accept    = ivalid && iready;
   assign push      = accept && last_lane;
   assign ovalid    = (count_reg != 2'd0);
   assign pop       = ovalid && oready;
   assign out_s0    = fifo_mem[rd_ptr_reg];
   assign done      = (state_reg == S_DONE);

   // The element lands in its lane combinationally so a completing word can be
   // pushed in the same edge that accepts its final element.
   always_comb begin
      word_next = asm_reg;
      word_next[lane_reg*STREAMW +: STREAMW] = in_s0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_FILL;
         lane_reg    <= '0;
         ecnt_reg    <= '0;
         asm_reg     <= '0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr_reg  <= 1'b0;
         rd_ptr_reg  <= 1'b0;
         count_reg   <= 2'd0;
      end else begin
         if (accept) begin
            asm_reg  <= word_next;
            lane_reg <= last_lane ? '0 : lane_reg + LW'(1);
            ecnt_reg <= ecnt_reg + EW'(1);
         end

         if (push) begin
            fifo_mem[wr_ptr_reg] <= word_next;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end

         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase

         case (state_reg)
            S_FILL: begin
               if (accept && (ecnt_reg == LAST_ECNT)) begin
                  state_reg <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (count_reg == 2'd0) begin
                  state_reg <= S_DONE;
               end
            end
            default: state_reg <= S_DONE;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel_a_vout_packer.sv
// Directed and randomised checks of kernel_a_vout_packer: two instances
// (NELEMS=8 and NELEMS=16) sharing clock and reset.
module tb_kernel_a_vout_packer;

   localparam int W = 32;
   localparam int P = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic           ivalid_a, iready_a, ovalid_a, oready_a, done_a;
   logic [W-1:0]   in_a;
   logic [P*W-1:0] out_a;
   logic           ivalid_b, iready_b, ovalid_b, oready_b, done_b;
   logic [W-1:0]   in_b;
   logic [P*W-1:0] out_b;

   kernel_a_vout_packer #(.STREAMW(W), .PACK(P), .NELEMS(8)) dut_a (
      .clk(clk), .rst(rst), .ivalid(ivalid_a), .iready(iready_a), .in_s0(in_a),
      .ovalid(ovalid_a), .oready(oready_a), .out_s0(out_a), .done(done_a)
   );

   kernel_a_vout_packer #(.STREAMW(W), .PACK(P), .NELEMS(16)) dut_b (
      .clk(clk), .rst(rst), .ivalid(ivalid_b), .iready(iready_b), .in_s0(in_b),
      .ovalid(ovalid_b), .oready(oready_b), .out_s0(out_b), .done(done_b)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] q [$];

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [127:0] take_word();
      logic [127:0] w;
      w = '0;
      for (int j = 0; j < P; j++) begin
         w[j*W +: W] = q.pop_front();
      end
      return w;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sent;
      int words;
      rst = 1'b1;
      ivalid_a = 1'b0; oready_a = 1'b0; in_a = '0;
      ivalid_b = 1'b0; oready_b = 1'b0; in_b = '0;
      tick();
      tick();

      // reset state while rst is high
      check_val("rst_iready", 128'(iready_a), 128'(0));
      check_val("rst_ovalid", 128'(ovalid_a), 128'(0));
      check_val("rst_done",   128'(done_a),   128'(0));
      check_val("rst_out",    128'(out_a),    128'(0));
      rst = 1'b0;
      #1;
      check_val("rst_rel_iready", 128'(iready_a), 128'(1));

      // continuous stream, NELEMS=8: 1..8 -> two words, then drain and done
      oready_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ivalid_a = 1'b1;
         in_a     = W'(i + 1);
         check_val("cont_iready", 128'(iready_a), 128'(1));
         tick();
         check_val("cont_ovalid", 128'(ovalid_a), 128'((i == 3) || (i == 7)));
         if (i == 3) check_val("cont_word0", 128'(out_a), 128'h00000004_00000003_00000002_00000001);
         if (i == 7) check_val("cont_word1", 128'(out_a), 128'h00000008_00000007_00000006_00000005);
      end
      check_val("cont_iready_drain", 128'(iready_a), 128'(0));
      tick();
      check_val("cont_ovalid_empty", 128'(ovalid_a), 128'(0));
      check_val("cont_done_early", 128'(done_a), 128'(0));
      tick();
      check_val("cont_done", 128'(done_a), 128'(1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("cont_done_sticky", 128'(done_a), 128'(1));
         check_val("cont_iready_done", 128'(iready_a), 128'(0));
      end
      ivalid_a = 1'b0;

      // backpressure, NELEMS=16: 12 elements offered with oready=0
      oready_b = 1'b0;
      for (int k = 0; k < 11; k++) begin
         ivalid_b = 1'b1;
         in_b     = W'(32'h100 + k);
         check_val("bp_iready", 128'(iready_b), 128'(1));
         tick();
      end
      in_b = 32'h10b;
      check_val("bp_iready_full", 128'(iready_b), 128'(0));
      check_val("bp_ovalid", 128'(ovalid_b), 128'(1));
      check_val("bp_head0", 128'(out_b), 128'h00000103_00000102_00000101_00000100);
      tick();
      check_val("bp_iready_still", 128'(iready_b), 128'(0));
      oready_b = 1'b1;
      tick();
      oready_b = 1'b0;
      check_val("bp_iready_back", 128'(iready_b), 128'(1));
      check_val("bp_head1", 128'(out_b), 128'h00000107_00000106_00000105_00000104);
      tick();
      ivalid_b = 1'b0;
      check_val("bp_hold", 128'(out_b), 128'h00000107_00000106_00000105_00000104);
      tick();
      check_val("bp_hold2", 128'(out_b), 128'h00000107_00000106_00000105_00000104);
      oready_b = 1'b1;
      tick();
      check_val("bp_ovalid2", 128'(ovalid_b), 128'(1));
      check_val("bp_head2", 128'(out_b), 128'h0000010b_0000010a_00000109_00000108);
      tick();
      check_val("bp_empty", 128'(ovalid_b), 128'(0));
      oready_b = 1'b0;

      // asynchronous reset mid-group with one buffered word
      do_reset();
      for (int k = 0; k < 6; k++) begin
         ivalid_b = 1'b1;
         in_b     = W'(32'h200 + k);
         tick();
      end
      ivalid_b = 1'b0;
      check_val("ar_pre_ovalid", 128'(ovalid_b), 128'(1));
      #2;
      rst = 1'b1;
      #1;
      check_val("ar_ovalid", 128'(ovalid_b), 128'(0));
      check_val("ar_iready", 128'(iready_b), 128'(0));
      check_val("ar_out",    128'(out_b),    128'(0));
      tick();
      rst = 1'b0;
      #1;
      check_val("ar_rel_iready", 128'(iready_b), 128'(1));
      oready_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ivalid_b = 1'b1;
         in_b     = W'(32'hA + k);
         tick();
      end
      ivalid_b = 1'b0;
      check_val("ar_ovalid_new", 128'(ovalid_b), 128'(1));
      check_val("ar_word_new", 128'(out_b), 128'h0000000d_0000000c_0000000b_0000000a);
      tick();
      check_val("ar_popped", 128'(ovalid_b), 128'(0));

      // random ivalid/oready over a full 16-element run
      do_reset();
      q.delete();
      sent  = 0;
      words = 0;
      for (int cyc = 0; cyc < 3000 && !(words == 4 && done_b); cyc++) begin
         ivalid_b = 1'($urandom_range(0, 1));
         oready_b = 1'($urandom_range(0, 1));
         in_b     = 32'hC000_0000 + W'(sent);
         #1;
         if (ovalid_b && oready_b) begin
            if (q.size() < P) begin
               check_val("rnd_underflow", 128'(q.size()), 128'(P));
            end else begin
               check_val("rnd_word", 128'(out_b), take_word());
            end
            $display("pop word %0d: %h", words, out_b);
            words++;
         end
         if (ivalid_b && iready_b) begin
            q.push_back(in_b);
            sent++;
         end
         tick();
      end
      check_val("rnd_sent",  128'(sent),  128'(16));
      check_val("rnd_words", 128'(words), 128'(4));
      check_val("rnd_left",  128'(q.size()), 128'(0));
      check_val("rnd_done",  128'(done_b), 128'(1));
      ivalid_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("rnd_done_sticky", 128'(done_b), 128'(1));
         check_val("rnd_iready_done", 128'(iready_b), 128'(0));
      end
      ivalid_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
